pwm_clock_gen_mc: RTL and testbench
===================================

Name: pwm_clock_gen_mc

Overview:
Multi-channel programmable clock/PWM generator. It is the parametrised successor of the single-channel divided-clock generator: channel count and counter width are parameters, and each channel takes a free period and high-time. New settings are double-buffered and applied only at a period boundary, so reprogramming is glitch-free. It sits between the register/switch interface and the timing outputs of FPGA prototype designs.

Parameters:
NCH, 4, number of independent channels (1..16)
CW, 16, counter/period/high-time width in bits (4..32)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  NCH  per-channel run enable
load  input  NCH  per-channel one-cycle strobe; captures period_in/high_in slice into shadow
period_in  input  NCH*CW  channel i period in clk cycles, bits [i*CW +: CW]
high_in  input  NCH*CW  channel i high-time in clk cycles, bits [i*CW +: CW]
clk_out  output  NCH  generated clock/PWM per channel, registered
wrap  output  NCH  one-cycle pulse on the last count of each period
pending  output  NCH  shadow holds values not yet applied

Behaviour:
- Reset (rst_n=0, async): cnt, active period/high, shadow, clk_out, wrap, pending all 0.
- Per channel registers: cnt[CW], act_per, act_hi, sh_per, sh_hi, pending. All channels are fully independent.
- Running (en[i]=1, act_per!=0): cnt counts 0..act_per-1 and then wraps to 0. wrap[i] is registered high in the cycle after cnt==act_per-1.
- clk_out[i] <= (cnt < act_hi), registered, so output lags the counter by 1 cycle.
  - act_hi=0 gives constant 0.
  - act_hi>=act_per gives constant 1.
  - Duty = act_hi/act_per exactly; no off-by-one.
- Comparisons are unsigned, full CW width. No multiplication; the period is the raw cycle count.
- load[i]=1: sh_per/sh_hi <= input slices and pending <= 1. Repeated loads before application: last one wins.
- Application while running: at the wrap edge (cnt==act_per-1) with pending=1, act <= sh, pending <= 0, cnt <= 0.
- Load coincident with wrap: input values bypass the shadow and go straight to active; pending stays 0.
- Application while idle (en[i]=0 or act_per==0): shadow goes to active on the cycle after load, and pending clears.
- en[i]=0: cnt held 0, clk_out 0, wrap 0. Active values are retained.
- en rising: first running cycle has cnt=0, so clk_out rises one cycle later if act_hi>0.
- en falling mid-period: next cycle cnt=0 and clk_out=0. The period is truncated; no completion.
- act_per=0: treated as stopped, identical to en=0.
- Reset mid-period: immediate async clear. No output glitch beyond the reset assertion itself.

Optional Feature:
- Macro PWM_CLOCK_GEN_PHASE_EN.
- Defined: adds input phase_in NCH*CW. On en rising edge, and on each idle-application, cnt starts at phase_in slice if it is < act_per, else 0. This gives per-channel phase offset between channels started together.
- Not defined: port absent; cnt always starts at 0.

Test Plan:
- Reset, then load ch0 per=10 hi=3 and en=1 -> clk_out0 pattern 3 high / 7 low repeating. wrap0 pulses every 10 cycles. pending0 returns to 0 one cycle after load.
- Ch1 running per=8 hi=4, load per=6 hi=1 at cnt=2 -> current 8-cycle period completes unchanged. pending1=1 until wrap. Then 1 high / 5 low, with no runt pulse.
- Boundary values ch2: hi=0 -> clk_out2 constant 0. hi=per=5 -> constant 1. per=0 -> clk_out2=0 and wrap2 never pulses.
- Load coincident with wrap on ch3 (per=4 → per=2 hi=1) -> next period immediately 2 cycles, 1 high. pending3 never asserts.
- Deassert en0 at cnt=5, then rst_n low mid-run on all channels -> clk_out0=0 the next cycle. Async reset clears all outputs without waiting for a clk edge.
- PHASE_EN build: ch0/ch1 per=8 hi=4, phase 0 and 4, enabled same cycle -> clk_out1 is the inverse of clk_out0. Phase 9 (>= per) starts at 0.

Source files
------------

// File: rtl/pwm_clock_gen_mc.sv
// Multi-channel PWM / divided-clock generator with double-buffered settings.
// Optional per-channel start phase: define PWM_CLOCK_GEN_PHASE_EN.
module pwm_clock_gen_mc #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    load,
  input  logic [NCH*CW-1:0] period_in,
  input  logic [NCH*CW-1:0] high_in,
`ifdef PWM_CLOCK_GEN_PHASE_EN
  input  logic [NCH*CW-1:0] phase_in,
`endif
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    wrap,
  output logic [NCH-1:0]    pending
);

  localparam logic [CW-1:0] ONE = CW'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] act_per;
    logic [CW-1:0] act_hi;
    logic [CW-1:0] sh_per;
    logic [CW-1:0] sh_hi;
    logic [CW-1:0] in_per;
    logic [CW-1:0] in_hi;
    logic [CW-1:0] per_d;
    logic [CW-1:0] start;
    logic          run;
    logic          at_end;
    logic          load_wrap;
    logic          apply;
    logic          pend_q;
    logic          out_q;
    logic          wrap_q;

    assign in_per    = period_in[i*CW +: CW];
    assign in_hi     = high_in[i*CW +: CW];
    assign run       = en[i] && (act_per != '0);
    assign at_end    = run && (cnt == act_per - ONE);
    assign load_wrap = load[i] && at_end;
    assign apply     = pend_q && !load[i] && (!run || at_end);

    // Period that will be active after this edge; phase is checked against it.
    assign per_d = load_wrap ? in_per :
                   apply     ? sh_per : act_per;

`ifdef PWM_CLOCK_GEN_PHASE_EN
    logic [CW-1:0] ph;
    assign ph    = phase_in[i*CW +: CW];
    assign start = (ph < per_d) ? ph : '0;
`else
    assign start = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        act_per <= '0;
        act_hi  <= '0;
        sh_per  <= '0;
        sh_hi   <= '0;
        pend_q  <= 1'b0;
        out_q   <= 1'b0;
        wrap_q  <= 1'b0;
      end else begin
        if (load_wrap) begin
          act_per <= in_per;
          act_hi  <= in_hi;
        end else if (apply) begin
          act_per <= sh_per;
          act_hi  <= sh_hi;
        end
        if (load[i] && !load_wrap) begin
          sh_per <= in_per;
          sh_hi  <= in_hi;
        end
        if (load[i])
          pend_q <= !at_end;
        else if (apply)
          pend_q <= 1'b0;
        if (!run)
          cnt <= start;
        else if (at_end)
          cnt <= '0;
        else
          cnt <= cnt + ONE;
        out_q  <= run && (cnt < act_hi);
        wrap_q <= at_end;
      end
    end

    assign clk_out[i] = out_q;
    assign wrap[i]    = wrap_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_pwm_clock_gen_mc.sv
// Directed bench for pwm_clock_gen_mc (NCH=4, CW=16).
// Phase checks run only when PWM_CLOCK_GEN_PHASE_EN is defined.
module tb_pwm_clock_gen_mc;

  localparam int NCH = 4;
  localparam int CW  = 16;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    load;
  logic [NCH*CW-1:0] period_in;
  logic [NCH*CW-1:0] high_in;
`ifdef PWM_CLOCK_GEN_PHASE_EN
  logic [NCH*CW-1:0] phase_in;
`endif
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    wrap;
  logic [NCH-1:0]    pending;

  int errors = 0;
  int checks = 0;

  pwm_clock_gen_mc #(.NCH(NCH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .period_in (period_in),
    .high_in   (high_in),
`ifdef PWM_CLOCK_GEN_PHASE_EN
    .phase_in  (phase_in),
`endif
    .clk_out   (clk_out),
    .wrap      (wrap),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int per, input int hi);
    period_in[ch*CW +: CW] = CW'(per);
    high_in[ch*CW +: CW]   = CW'(hi);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (clk_out !== '0 || wrap !== '0 || pending !== '0) begin
      errors++;
      $display("FAIL reset: clk_out=%b wrap=%b pending=%b want 0",
               clk_out, wrap, pending);
    end
  endtask

  task automatic test_ch0_basic();
    logic e;
    set_ch(0, 10, 3);
    load[0] = 1'b1;
    en[0]   = 1'b1;
    step();
    load[0] = 1'b0;
    checks++;
    if (pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL ch0_pend_set: got %b want 1", pending[0]);
    end
    step();
    checks++;
    if (pending[0] !== 1'b0) begin
      errors++;
      $display("FAIL ch0_pend_clr: got %b want 0", pending[0]);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      e = ((k % 10) < 3);
      checks++;
      if (clk_out[0] !== e) begin
        errors++;
        $display("FAIL ch0_clk k=%0d: got %b want %b", k, clk_out[0], e);
      end
      e = ((k % 10) == 9);
      checks++;
      if (wrap[0] !== e) begin
        errors++;
        $display("FAIL ch0_wrap k=%0d: got %b want %b", k, wrap[0], e);
      end
    end
  endtask

  task automatic test_ch1_reload();
    logic e;
    set_ch(1, 8, 4);
    load[1] = 1'b1;
    en[1]   = 1'b1;
    step();
    load[1] = 1'b0;
    step();
    set_ch(1, 6, 1);
    for (int k = 0; k < 20; k++) begin
      load[1] = (k == 2);
      step();
      load[1] = 1'b0;
      e = (k < 8) ? ((k % 8) < 4) : (((k - 8) % 6) < 1);
      checks++;
      if (clk_out[1] !== e) begin
        errors++;
        $display("FAIL ch1_clk k=%0d: got %b want %b", k, clk_out[1], e);
      end
      e = (k < 8) ? (k == 7) : (((k - 8) % 6) == 5);
      checks++;
      if (wrap[1] !== e) begin
        errors++;
        $display("FAIL ch1_wrap k=%0d: got %b want %b", k, wrap[1], e);
      end
      e = (k >= 2 && k <= 6);
      checks++;
      if (pending[1] !== e) begin
        errors++;
        $display("FAIL ch1_pend k=%0d: got %b want %b", k, pending[1], e);
      end
    end
  endtask

  task automatic test_ch2_bounds();
    set_ch(2, 5, 0);
    load[2] = 1'b1;
    en[2]   = 1'b1;
    step();
    load[2] = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (clk_out[2] !== 1'b0) begin
        errors++;
        $display("FAIL ch2_hi0 k=%0d: got %b want 0", k, clk_out[2]);
      end
    end
    set_ch(2, 5, 5);
    load[2] = 1'b1;
    step();
    load[2] = 1'b0;
    repeat (7) step();
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (clk_out[2] !== 1'b1) begin
        errors++;
        $display("FAIL ch2_hieqper k=%0d: got %b want 1", k, clk_out[2]);
      end
    end
    set_ch(2, 0, 3);
    load[2] = 1'b1;
    step();
    load[2] = 1'b0;
    repeat (7) step();
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (clk_out[2] !== 1'b0 || wrap[2] !== 1'b0) begin
        errors++;
        $display("FAIL ch2_per0 k=%0d: clk=%b wrap=%b want 0 0",
                 k, clk_out[2], wrap[2]);
      end
    end
  endtask

  task automatic test_ch3_load_at_wrap();
    logic e;
    set_ch(3, 4, 2);
    load[3] = 1'b1;
    en[3]   = 1'b1;
    step();
    load[3] = 1'b0;
    step();
    set_ch(3, 2, 1);
    for (int k = 0; k < 12; k++) begin
      load[3] = (k == 3);
      step();
      load[3] = 1'b0;
      e = (k <= 3) ? ((k % 4) < 2) : (((k - 4) % 2) < 1);
      checks++;
      if (clk_out[3] !== e) begin
        errors++;
        $display("FAIL ch3_clk k=%0d: got %b want %b", k, clk_out[3], e);
      end
      e = (k <= 3) ? (k == 3) : (((k - 4) % 2) == 1);
      checks++;
      if (wrap[3] !== e) begin
        errors++;
        $display("FAIL ch3_wrap k=%0d: got %b want %b", k, wrap[3], e);
      end
      checks++;
      if (pending[3] !== 1'b0) begin
        errors++;
        $display("FAIL ch3_pend k=%0d: got %b want 0", k, pending[3]);
      end
    end
  endtask

  task automatic test_en_and_reset();
    en[0] = 1'b0;
    step();
    step();
    checks++;
    if (clk_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL en_off: got %b want 0", clk_out[0]);
    end
    en[0] = 1'b1;
    step();
    checks++;
    if (clk_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL en_rise: got %b want 1", clk_out[0]);
    end
    repeat (4) step();
    en[0] = 1'b0;
    step();
    checks++;
    if (clk_out[0] !== 1'b0 || wrap[0] !== 1'b0) begin
      errors++;
      $display("FAIL en_fall: clk=%b wrap=%b want 0 0", clk_out[0], wrap[0]);
    end
    en[0] = 1'b1;
    step();
    checks++;
    if (clk_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL en_restart: got %b want 1", clk_out[0]);
    end
    set_ch(1, 9, 2);
    load[1] = 1'b1;
    step();
    load[1] = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (clk_out !== '0 || wrap !== '0 || pending !== '0) begin
      errors++;
      $display("FAIL async_rst: clk_out=%b wrap=%b pending=%b want 0",
               clk_out, wrap, pending);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (clk_out !== '0 || pending !== '0) begin
      errors++;
      $display("FAIL post_rst: clk_out=%b pending=%b want 0", clk_out, pending);
    end
  endtask

`ifdef PWM_CLOCK_GEN_PHASE_EN
  task automatic test_phase();
    logic e0;
    logic e1;
    en = '0;
    for (int c = 0; c < 3; c++) set_ch(c, 8, 4);
    phase_in[0*CW +: CW] = CW'(0);
    phase_in[1*CW +: CW] = CW'(4);
    phase_in[2*CW +: CW] = CW'(9);
    load = 4'b0111;
    step();
    load = '0;
    step();
    en = 4'b0111;
    for (int k = 0; k < 16; k++) begin
      step();
      e0 = ((k % 8) < 4);
      e1 = (((k + 4) % 8) < 4);
      checks++;
      if (clk_out[0] !== e0 || clk_out[1] !== e1 || clk_out[2] !== e0) begin
        errors++;
        $display("FAIL phase k=%0d: got %b%b%b want %b%b%b", k,
                 clk_out[2], clk_out[1], clk_out[0], e0, e1, e0);
      end
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    en        = '0;
    load      = '0;
    period_in = '0;
    high_in   = '0;
`ifdef PWM_CLOCK_GEN_PHASE_EN
    phase_in  = '0;
`endif
    test_reset();
    test_ch0_basic();
    test_ch1_reload();
    test_ch2_bounds();
    test_ch3_load_at_wrap();
    test_en_and_reset();
`ifdef PWM_CLOCK_GEN_PHASE_EN
    test_phase();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
